for_loop_step_ctrl: RTL
=======================

// Module: for_loop_step_ctrl
// PURPOSE
//  Loop-body sequencer paired with the forLoop iteration counter. Owns the counter's en and forValid inputs.
//  Runs a loop body once per iteration index j (1..n_iter) via a start/done handshake, then pulses the
//  counter's step input. On the last iteration it drops counter enable, which rewinds j to 1.
//  Sits between the layer FSM (start/loop_done) and the gate compute pipeline (body_start/body_done).
// PARAMETERS
//  jW   5   width of j, n_iter and internal iteration count; n_iter max = 2^jW-1
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    synchronous reset, active-low
//  en          in   1    block enable; 0 acts like reset (abort)
//  start       in   1    1-cycle request to run a loop; sampled only in IDLE
//  n_iter      in   jW   iteration count, latched on accepted start
//  j_in        in   jW   j from counter
//  j_valid     in   1    valid from counter
//  cnt_en      out  1    drives counter en
//  step        out  1    drives counter forValid; 1-cycle pulse per finished iteration
//  body_start  out  1    1-cycle pulse: launch loop body for index body_idx
//  body_idx    out  jW   index of current body, held from body_start until body_done
//  body_done   in   1    pipeline reports current body finished; ignored outside WAIT_BODY
//  busy        out  1    1 in any state other than IDLE
//  loop_done   out  1    1-cycle pulse after last step
//  idx_err     out  1    sticky: j_in != internal count at issue; cleared on accepted start
// BEHAVIOUR
//  - Outputs: all registered.
//  - Reset (rst_n=0 at posedge) or en=0: state IDLE; all outputs 0, including idx_err; count=1.
//  - States and transitions:
//     IDLE      : start=1 and n_iter!=0 -> ARM, set cnt_en=1, latch n_iter, count=1, clear idx_err.
//                 start=1 and n_iter==0 -> DONE (cnt_en stays 0, no body, no step).
//     ARM       : wait for j_valid=1 (counter valid lags en by 1 cycle) -> ISSUE.
//     ISSUE     : body_start=1 for one cycle; body_idx<=count. If j_in!=count, set idx_err (sticky).
//                 -> WAIT_BODY.
//     WAIT_BODY : body_done=1 -> STEP.
//     STEP      : step=1 for one cycle.
//                 If count==n_iter_latched -> DONE, cnt_en<=0.
//                 Else count<=count+1 -> SETTLE.
//     SETTLE    : 1 cycle so the counter's j update is visible -> ISSUE.
//     DONE      : loop_done=1 for one cycle, cnt_en=0 -> IDLE.
//  - Latency: start to first body_start = 3 cycles (IDLE->ARM->ISSUE with j_valid). Iteration overhead
//    beyond body latency = 3 cycles (ISSUE, STEP, SETTLE).
//  - Bound: n_iter=2^jW-1 is legal; count never wraps, because the last STEP exits before increment.
//  - Input overlap: start while busy is ignored; n_iter changes after latch are ignored.
//  - body_done in the same cycle as body_start is not seen; it is sampled from WAIT_BODY on.
//  - en or rst_n low mid-loop: immediate return to IDLE, cnt_en=0 (counter rewinds), no loop_done.
//  - j_valid dropping outside ARM: no effect on state.
// TESTING
//  1. n_iter=3, body_done 2 cycles after each body_start -> body_idx 1,2,3; exactly 3 step pulses;
//     loop_done once; cnt_en low after; idx_err=0.
//  2. n_iter=0 -> loop_done 2 cycles after start; no body_start, no step; cnt_en never 1.
//  3. jW=5, n_iter=31 -> 31 bodies; last body_idx=31; counter j never reaches 0.
//  4. start pulsed again during loop (n_iter=2 running, start with n_iter=7) -> ignored; 2 iterations only.
//  5. Force j_in=5 at 2nd ISSUE -> idx_err=1 and stays 1 through loop_done; clears on next start.
//  6. rst_n=0 (then en=0) during WAIT_BODY of iter 2 -> next cycle IDLE, all outputs 0; new start with
//     n_iter=1 runs cleanly from j=1.

Source files
------------

// File: rtl/for_loop_step_ctrl.sv
// Loop-body sequencer for the forLoop iteration counter.
// Runs one body per iteration index through a start/done handshake with the
// compute pipeline, pulses the counter step after each body, and drops the
// counter enable after the last step so the counter rewinds to j=1.
module for_loop_step_ctrl #(
    parameter int jW = 5
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          en_i,
    input  logic          start_i,
    input  logic [jW-1:0] n_iter_i,
    input  logic [jW-1:0] j_in_i,
    input  logic          j_valid_i,
    output logic          cnt_en_o,
    output logic          step_o,
    output logic          body_start_o,
    output logic [jW-1:0] body_idx_o,
    input  logic          body_done_i,
    output logic          busy_o,
    output logic          loop_done_o,
    output logic          idx_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ISSUE,
        S_WAIT_BODY,
        S_STEP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [jW-1:0] count_q, count_d;
    logic [jW-1:0] n_q, n_d;
    logic          cnt_en_q, cnt_en_d;
    logic          idx_err_q, idx_err_d;
    logic          step_q, body_start_q, busy_q, loop_done_q;
    logic [jW-1:0] body_idx_q;

    // Next-state logic; the last STEP exits before the increment so count never wraps.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        n_d       = n_q;
        cnt_en_d  = cnt_en_q;
        idx_err_d = idx_err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_err_d = 1'b0;
                    if (n_iter_i != '0) begin
                        state_d  = S_ARM;
                        cnt_en_d = 1'b1;
                        n_d      = n_iter_i;
                        count_d  = jW'(1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ARM: begin
                if (j_valid_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (j_in_i != count_q) idx_err_d = 1'b1;
                state_d = S_WAIT_BODY;
            end
            S_WAIT_BODY: begin
                if (body_done_i) state_d = S_STEP;
            end
            S_STEP: begin
                if (count_q == n_q) begin
                    state_d  = S_DONE;
                    cnt_en_d = 1'b0;
                end else begin
                    count_d = count_q + jW'(1);
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_ISSUE;
            end
            S_DONE: begin
                cnt_en_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                cnt_en_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset and en=0 both abort to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !en_i) begin
            state_q      <= S_IDLE;
            count_q      <= jW'(1);
            n_q          <= '0;
            cnt_en_q     <= 1'b0;
            idx_err_q    <= 1'b0;
            step_q       <= 1'b0;
            body_start_q <= 1'b0;
            body_idx_q   <= '0;
            busy_q       <= 1'b0;
            loop_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            n_q          <= n_d;
            cnt_en_q     <= cnt_en_d;
            idx_err_q    <= idx_err_d;
            step_q       <= (state_d == S_STEP);
            body_start_q <= (state_d == S_ISSUE);
            if (state_d == S_ISSUE) body_idx_q <= count_d;
            busy_q       <= (state_d != S_IDLE);
            loop_done_q  <= (state_q == S_DONE);
        end
    end

    assign cnt_en_o     = cnt_en_q;
    assign step_o       = step_q;
    assign body_start_o = body_start_q;
    assign body_idx_o   = body_idx_q;
    assign busy_o       = busy_q;
    assign loop_done_o  = loop_done_q;
    assign idx_err_o    = idx_err_q;

endmodule
